v2_deque_op_issuer: RTL and testbench

//  Initiator side of the v2 deque op handshake. Accepts one deque command at
//  a time on a val/rdy port and drives the matching enq_back/enq_front/
//  deq_front/deq_back req pulse toward the deque controller.

---
 rtl/v2_deque_pkg.sv | 26 ++
 rtl/v2_deque_retry_ctr.sv | 29 ++
 rtl/v2_deque_op_issuer.sv | 145 ++++++++++++++
 tb/tb_v2_deque_op_issuer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v2_deque_pkg.sv
// Types shared by the v2 deque issuer and the v2 deque controller.
package v2_deque_pkg;

   typedef enum logic [1:0] {
      OP_ENQ_BACK  = 2'd0,
      OP_ENQ_FRONT = 2'd1,
      OP_DEQ_FRONT = 2'd2,
      OP_DEQ_BACK  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int NUM_OPS = 4;

   // One-hot request lane for an opcode; bit order follows op_t encoding.
   function automatic logic [NUM_OPS-1:0] op_onehot(input op_t op);
      op_onehot     = '0;
      op_onehot[op] = 1'b1;
   endfunction

endpackage

// File: rtl/v2_deque_retry_ctr.sv
// Saturating retry counter: clear on a new command, step once per failed attempt.
module v2_deque_retry_ctr #(
   parameter int p_max_retry  = 15,
   parameter int p_retrywidth = $clog2(p_max_retry + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic done
);

   // A zero-retry build still needs a one-bit counter to hold the value 0.
   localparam int CW = (p_retrywidth < 1) ? 1 : p_retrywidth;
   localparam logic [CW-1:0] MAX_CNT = CW'(p_max_retry);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (inc && (cnt_reg != MAX_CNT)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign done = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/v2_deque_op_issuer.sv
// Initiator for the v2 deque op handshake: one command in flight, a req pulse per
// attempt, bounded retries, result returned on a val/rdy response port.
module v2_deque_op_issuer
   import v2_deque_pkg::*;
#(
   parameter int p_bitwidth   = 32,
   parameter int p_max_retry  = 15,
   parameter int p_retrywidth = $clog2(p_max_retry + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_val,
   output logic                  cmd_rdy,
   input  logic [1:0]            cmd_op,
   input  logic [p_bitwidth-1:0] cmd_data,
   output logic                  resp_val,
   input  logic                  resp_rdy,
   output logic [1:0]            resp_op,
   output logic [p_bitwidth-1:0] resp_data,
   output logic                  resp_err,
   output logic                  enq_back_req,
   output logic                  enq_front_req,
   output logic                  deq_front_req,
   output logic                  deq_back_req,
   input  logic                  enq_back_cpl,
   input  logic                  enq_front_cpl,
   input  logic                  deq_front_cpl,
   input  logic                  deq_back_cpl,
   output logic [p_bitwidth-1:0] enq_back_data,
   output logic [p_bitwidth-1:0] enq_front_data,
   input  logic [p_bitwidth-1:0] deq_front_data,
   input  logic [p_bitwidth-1:0] deq_back_data
);

   state_t                state_reg;
   op_t                   op_reg;
   op_t                   resp_op_reg;
   logic [p_bitwidth-1:0] data_reg;
   logic [p_bitwidth-1:0] resp_data_reg;
   logic                  resp_err_reg;
   logic [NUM_OPS-1:0]    req_reg;
   logic [NUM_OPS-1:0]    req_gated;
   logic [NUM_OPS-1:0]    cpl_vec;
   logic                  cpl_match;
   logic [p_bitwidth-1:0] deq_data;
   logic                  retry_clr;
   logic                  retry_inc;
   logic                  retry_done;
   logic                  op_active;

   // Only the completion lane of the issued op counts; others are spurious.
   assign cpl_vec   = {deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl};
   assign cpl_match = cpl_vec[op_reg];
   assign deq_data  = (op_reg == OP_DEQ_BACK)  ? deq_back_data  :
                      (op_reg == OP_DEQ_FRONT) ? deq_front_data : '0;

   assign retry_clr = (state_reg == ST_IDLE) && cmd_val;
   assign retry_inc = (state_reg == ST_WAIT) && !cpl_match && !retry_done;

   v2_deque_retry_ctr #(
      .p_max_retry  (p_max_retry),
      .p_retrywidth (p_retrywidth)
   ) u_retry_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (retry_clr),
      .inc  (retry_inc),
      .done (retry_done)
   );

   // req_reg is loaded on entry to ISSUE, so each pulse is exactly one cycle wide.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         op_reg        <= OP_ENQ_BACK;
         data_reg      <= '0;
         req_reg       <= '0;
         resp_op_reg   <= OP_ENQ_BACK;
         resp_data_reg <= '0;
         resp_err_reg  <= 1'b0;
      end else begin
         req_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (cmd_val) begin
                  op_reg    <= op_t'(cmd_op);
                  data_reg  <= cmd_data;
                  req_reg   <= op_onehot(op_t'(cmd_op));
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cpl_match) begin
                  resp_op_reg   <= op_reg;
                  resp_data_reg <= deq_data;
                  resp_err_reg  <= 1'b0;
                  state_reg     <= ST_RESP;
               end else if (!retry_done) begin
                  req_reg   <= op_onehot(op_reg);
                  state_reg <= ST_ISSUE;
               end else begin
                  resp_op_reg   <= op_reg;
                  resp_data_reg <= '0;
                  resp_err_reg  <= 1'b1;
                  state_reg     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_rdy) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi = gi + 1) begin : g_req
         assign req_gated[gi] = req_reg[gi] & ~rst;
      end
   endgenerate

   assign enq_back_req  = req_gated[OP_ENQ_BACK];
   assign enq_front_req = req_gated[OP_ENQ_FRONT];
   assign deq_front_req = req_gated[OP_DEQ_FRONT];
   assign deq_back_req  = req_gated[OP_DEQ_BACK];

   assign op_active      = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
   assign enq_back_data  = op_active ? data_reg : '0;
   assign enq_front_data = op_active ? data_reg : '0;

   assign cmd_rdy   = (state_reg == ST_IDLE) && !rst;
   assign resp_val  = (state_reg == ST_RESP) && !rst;
   assign resp_op   = resp_op_reg;
   assign resp_data = resp_data_reg;
   assign resp_err  = resp_err_reg;

endmodule

// File: tb/tb_v2_deque_op_issuer.sv
// Directed bench: issuer against a behavioural depth-4 deque controller.
module tb_v2_deque_op_issuer;
   import v2_deque_pkg::*;

   localparam int BW    = 32;
   localparam int MR    = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_val = 1'b0;
   logic          cmd_rdy;
   logic [1:0]    cmd_op = 2'd0;
   logic [BW-1:0] cmd_data = '0;
   logic          resp_val;
   logic          resp_rdy = 1'b1;
   logic [1:0]    resp_op;
   logic [BW-1:0] resp_data;
   logic          resp_err;
   logic          enq_back_req, enq_front_req, deq_front_req, deq_back_req;
   logic          enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl;
   logic [BW-1:0] enq_back_data, enq_front_data, deq_front_data, deq_back_data;

   logic          ctl_ebc = 1'b0, ctl_efc = 1'b0, ctl_dfc = 1'b0, ctl_dbc = 1'b0;
   logic [BW-1:0] ctl_dfd = '0, ctl_dbd = '0;
   logic          force_dbc = 1'b0;
   logic [BW-1:0] dq[$];
   logic [3:0]    reqs;

   int checks = 0;
   int errors = 0;
   int onehot_viol = 0;
   int pulse_cyc[16];

   always #5 clk = ~clk;

   v2_deque_op_issuer #(
      .p_bitwidth  (BW),
      .p_max_retry (MR)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_val        (cmd_val),
      .cmd_rdy        (cmd_rdy),
      .cmd_op         (cmd_op),
      .cmd_data       (cmd_data),
      .resp_val       (resp_val),
      .resp_rdy       (resp_rdy),
      .resp_op        (resp_op),
      .resp_data      (resp_data),
      .resp_err       (resp_err),
      .enq_back_req   (enq_back_req),
      .enq_front_req  (enq_front_req),
      .deq_front_req  (deq_front_req),
      .deq_back_req   (deq_back_req),
      .enq_back_cpl   (enq_back_cpl),
      .enq_front_cpl  (enq_front_cpl),
      .deq_front_cpl  (deq_front_cpl),
      .deq_back_cpl   (deq_back_cpl),
      .enq_back_data  (enq_back_data),
      .enq_front_data (enq_front_data),
      .deq_front_data (deq_front_data),
      .deq_back_data  (deq_back_data)
   );

   assign reqs           = {deq_back_req, deq_front_req, enq_front_req, enq_back_req};
   assign enq_back_cpl   = ctl_ebc;
   assign enq_front_cpl  = ctl_efc;
   assign deq_front_cpl  = ctl_dfc;
   assign deq_back_cpl   = ctl_dbc | force_dbc;
   assign deq_front_data = ctl_dfd;
   assign deq_back_data  = ctl_dbd;

   // Controller model: accepted req performs the op, cpl one cycle later.
   always @(posedge clk) begin
      ctl_ebc <= 1'b0;
      ctl_efc <= 1'b0;
      ctl_dfc <= 1'b0;
      ctl_dbc <= 1'b0;
      ctl_dfd <= 32'hBAD0_F00D;
      ctl_dbd <= 32'hBAD0_B00D;
      if ($countones(reqs) > 1) onehot_viol <= onehot_viol + 1;
      if (enq_back_req && dq.size() < DEPTH) begin
         dq.push_back(enq_back_data);
         ctl_ebc <= 1'b1;
      end
      if (enq_front_req && dq.size() < DEPTH) begin
         dq.push_front(enq_front_data);
         ctl_efc <= 1'b1;
      end
      if (deq_front_req && dq.size() > 0) begin
         ctl_dfd <= dq.pop_front();
         ctl_dfc <= 1'b1;
      end
      if (deq_back_req && dq.size() > 0) begin
         ctl_dbd <= dq.pop_back();
         ctl_dbc <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake one command, then follow it until resp_val; lat counts from the handshake edge.
   task automatic issue_cmd(input op_t op, input logic [BW-1:0] d, output int lat,
                            output int npulse, output int nwrong, output logic [BW-1:0] edata,
                            output logic [1:0] rop, output logic [BW-1:0] rdata, output logic rerr);
      logic [3:0] cur;
      logic [3:0] mask;
      int         w;
      mask = 4'b0001 << op;
      w = 0;
      while (!cmd_rdy && w < 20) begin
         tick();
         w++;
      end
      checks++;
      if (!cmd_rdy) begin
         errors++;
         $display("FAIL cmd_rdy_timeout: cmd_rdy=%0b required 1", cmd_rdy);
      end
      cmd_val  = 1'b1;
      cmd_op   = op;
      cmd_data = d;
      tick();
      cmd_val  = 1'b0;
      npulse   = 0;
      nwrong   = 0;
      edata    = '0;
      for (lat = 1; lat < 200; lat++) begin
         cur = reqs;
         if ((cur & mask) != 4'b0000) begin
            if (npulse == 0) edata = (op == OP_ENQ_FRONT) ? enq_front_data : enq_back_data;
            if (npulse < 16) pulse_cyc[npulse] = lat;
            npulse++;
         end
         nwrong += $countones(cur & ~mask);
         if (resp_val) break;
         tick();
      end
      checks++;
      if (!resp_val) begin
         errors++;
         $display("FAIL resp_timeout: resp_val=%0b required 1 within 200 cycles", resp_val);
      end
      rop   = resp_op;
      rdata = resp_data;
      rerr  = resp_err;
      $display("txn op=%0d data=%h -> resp op=%0d data=%h err=%0b lat=%0d pulses=%0d",
               op, d, rop, rdata, rerr, lat, npulse);
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({cmd_rdy, resp_val, reqs} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: cmd_rdy=%0b resp_val=%0b reqs=%b required all 0", cmd_rdy, resp_val, reqs);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (cmd_rdy !== 1'b1 || resp_val !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: cmd_rdy=%0b resp_val=%0b required 1/0", cmd_rdy, resp_val);
      end
      checks++;
      if (resp_op !== 2'd0 || resp_data !== '0 || resp_err !== 1'b0 || enq_back_data !== '0) begin
         errors++;
         $display("FAIL reset_regs: op=%0d data=%h err=%0b edata=%h required 0", resp_op, resp_data, resp_err, enq_back_data);
      end
   endtask

   task automatic test_enq_deq();
      int lat, np, nw;
      logic [BW-1:0] ed, rd;
      logic [1:0] ro;
      logic re;
      issue_cmd(OP_ENQ_BACK, 32'hA5, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (lat !== 3 || np !== 1 || nw !== 0) begin
         errors++;
         $display("FAIL enq_timing: lat=%0d pulses=%0d wrong=%0d required 3/1/0", lat, np, nw);
      end
      checks++;
      if (ed !== 32'hA5 || ro !== 2'd0 || rd !== '0 || re !== 1'b0) begin
         errors++;
         $display("FAIL enq_resp: edata=%h op=%0d data=%h err=%0b required a5/0/0/0", ed, ro, rd, re);
      end
      tick();
      checks++;
      if (resp_val !== 1'b0 || cmd_rdy !== 1'b1 || enq_back_data !== '0) begin
         errors++;
         $display("FAIL enq_return_idle: resp_val=%0b cmd_rdy=%0b edata=%h required 0/1/0", resp_val, cmd_rdy, enq_back_data);
      end
      issue_cmd(OP_DEQ_FRONT, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (lat !== 3 || ro !== 2'd2 || rd !== 32'hA5 || re !== 1'b0) begin
         errors++;
         $display("FAIL deq_front_a5: lat=%0d op=%0d data=%h err=%0b required 3/2/a5/0", lat, ro, rd, re);
      end
      tick();
   endtask

   task automatic test_mixed();
      int lat, np, nw;
      logic [BW-1:0] ed, rd;
      logic [1:0] ro;
      logic re;
      issue_cmd(OP_ENQ_BACK, 32'd1, lat, np, nw, ed, ro, rd, re);
      tick();
      issue_cmd(OP_ENQ_BACK, 32'd2, lat, np, nw, ed, ro, rd, re);
      tick();
      issue_cmd(OP_ENQ_FRONT, 32'd9, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (ed !== 32'd9 || ro !== 2'd1 || re !== 1'b0 || np !== 1) begin
         errors++;
         $display("FAIL enq_front: edata=%h op=%0d err=%0b pulses=%0d required 9/1/0/1", ed, ro, re, np);
      end
      tick();
      issue_cmd(OP_DEQ_BACK, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (rd !== 32'd2 || ro !== 2'd3 || re !== 1'b0) begin
         errors++;
         $display("FAIL deq_back_2: data=%h op=%0d err=%0b required 2/3/0", rd, ro, re);
      end
      tick();
      issue_cmd(OP_DEQ_FRONT, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (rd !== 32'd9 || re !== 1'b0) begin
         errors++;
         $display("FAIL deq_front_9: data=%h err=%0b required 9/0", rd, re);
      end
      tick();
      issue_cmd(OP_DEQ_FRONT, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (rd !== 32'd1 || re !== 1'b0) begin
         errors++;
         $display("FAIL deq_front_1: data=%h err=%0b required 1/0", rd, re);
      end
      tick();
   endtask

   task automatic test_retry();
      int lat, np, nw;
      logic [BW-1:0] ed, rd;
      logic [1:0] ro;
      logic re;
      issue_cmd(OP_DEQ_FRONT, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (np !== MR + 1 || nw !== 0 || lat !== 9) begin
         errors++;
         $display("FAIL retry_count: pulses=%0d wrong=%0d lat=%0d required 4/0/9", np, nw, lat);
      end
      checks++;
      if (pulse_cyc[0] !== 1 || pulse_cyc[1] !== 3 || pulse_cyc[2] !== 5 || pulse_cyc[3] !== 7) begin
         errors++;
         $display("FAIL retry_spacing: cycles=%0d,%0d,%0d,%0d required 1,3,5,7",
                  pulse_cyc[0], pulse_cyc[1], pulse_cyc[2], pulse_cyc[3]);
      end
      checks++;
      if (re !== 1'b1 || rd !== '0 || ro !== 2'd2) begin
         errors++;
         $display("FAIL retry_err: err=%0b data=%h op=%0d required 1/0/2", re, rd, ro);
      end
      tick();
   endtask

   task automatic test_back_pressure();
      int lat, np, nw;
      logic [BW-1:0] ed, rd;
      logic [1:0] ro;
      logic re;
      issue_cmd(OP_ENQ_BACK, 32'h77, lat, np, nw, ed, ro, rd, re);
      tick();
      resp_rdy = 1'b0;
      issue_cmd(OP_DEQ_BACK, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (rd !== 32'h77 || lat !== 3) begin
         errors++;
         $display("FAIL bp_first: data=%h lat=%0d required 77/3", rd, lat);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (resp_val !== 1'b1 || resp_data !== 32'h77 || resp_err !== 1'b0 || resp_op !== 2'd3 ||
             cmd_rdy !== 1'b0 || reqs !== 4'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: val=%0b data=%h err=%0b op=%0d cmd_rdy=%0b reqs=%b required 1/77/0/3/0/0",
                     i, resp_val, resp_data, resp_err, resp_op, cmd_rdy, reqs);
         end
      end
      resp_rdy = 1'b1;
      tick();
      checks++;
      if (resp_val !== 1'b0 || cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: resp_val=%0b cmd_rdy=%0b required 0/1", resp_val, cmd_rdy);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat, np, nw;
      logic [BW-1:0] ed, rd;
      logic [1:0] ro;
      logic re;
      cmd_val = 1'b1; cmd_op = OP_ENQ_BACK; cmd_data = 32'h33;
      tick();
      cmd_val = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (reqs !== 4'b0 || resp_val !== 1'b0 || cmd_rdy !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_gate: reqs=%b resp_val=%0b cmd_rdy=%0b required 0", reqs, resp_val, cmd_rdy);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_rdy !== 1'b1 || resp_val !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_idle: cmd_rdy=%0b resp_val=%0b required 1/0", cmd_rdy, resp_val);
      end
      cmd_val = 1'b1; cmd_op = OP_ENQ_BACK; cmd_data = 32'h44;
      tick();
      cmd_val = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (reqs !== 4'b0) begin
         errors++;
         $display("FAIL rst_issue_gate: reqs=%b required 0000", reqs);
      end
      tick();
      rst = 1'b0;
      #1;
      issue_cmd(OP_DEQ_BACK, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (rd !== 32'h33 || re !== 1'b0 || lat !== 3) begin
         errors++;
         $display("FAIL rst_after_deq: data=%h err=%0b lat=%0d required 33/0/3", rd, re, lat);
      end
      tick();
      issue_cmd(OP_DEQ_BACK, 32'h0, lat, np, nw, ed, ro, rd, re);
      checks++;
      if (re !== 1'b1 || rd !== '0) begin
         errors++;
         $display("FAIL rst_gated_enq: err=%0b data=%h required 1/0 (0x44 must not be enqueued)", re, rd);
      end
      tick();
   endtask

   task automatic test_spurious_cpl();
      int n, c;
      cmd_val = 1'b1; cmd_op = OP_DEQ_FRONT; cmd_data = 32'h0;
      tick();
      cmd_val = 1'b0;
      tick();
      force_dbc = 1'b1;
      tick();
      force_dbc = 1'b0;
      checks++;
      if (reqs !== 4'b0100 || resp_val !== 1'b0) begin
         errors++;
         $display("FAIL spurious_retry: reqs=%b resp_val=%0b required 0100/0", reqs, resp_val);
      end
      n = 0;
      for (c = 3; c < 100; c++) begin
         if (deq_front_req) n++;
         if (resp_val) break;
         tick();
      end
      checks++;
      if (n !== MR || c !== 9 || resp_err !== 1'b1 || resp_data !== '0) begin
         errors++;
         $display("FAIL spurious_end: pulses=%0d cycle=%0d err=%0b data=%h required 3/9/1/0", n, c, resp_err, resp_data);
      end
      $display("txn op=2 spurious deq_back_cpl -> resp err=%0b data=%h", resp_err, resp_data);
      tick();
   endtask

   task automatic test_onehot();
      checks++;
      if (onehot_viol !== 0) begin
         errors++;
         $display("FAIL req_onehot: multi-req cycles=%0d required 0", onehot_viol);
      end
   endtask

   initial begin
      test_reset();
      test_enq_deq();
      test_mixed();
      test_retry();
      test_back_pressure();
      test_reset_mid_op();
      test_spurious_cpl();
      test_onehot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
